// File: rtl/text_console.sv
// Byte-stream front end for the text-mode display: consumes ASCII over valid/ready, tracks a
// cursor, and drives the video character memory write port, blanking rows as the cursor wraps.
module text_console #(
  parameter int unsigned COLS   = 50,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 11,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              CLK_CPU,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              video_write_enable,
  output logic [ADDR_W-1:0] video_write_addr,
  output logic [7:0]        video_write_data,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row
);

  typedef enum logic [1:0] {StIdle, StClearRow, StClearAll} state_e;

  localparam logic [5:0]        LastCol    = 6'(COLS - 1);
  localparam logic [4:0]        LastRow    = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LastRowClr = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LastAllClr = ADDR_W'(ROWS * COLS - 1);

  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChBs = 8'h08;
  localparam logic [7:0] ChFf = 8'h0C;

  state_e            state;
  logic [5:0]        col;
  logic [4:0]        row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] clr_cnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;

  logic              accept;
  logic              printable;
  logic              row_wrap;
  logic [4:0]        next_row;
  logic [ADDR_W-1:0] next_base;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] clr_addr;

  assign char_ready = (state == StIdle);
  assign accept     = char_valid && char_ready;
  assign printable  = (char_data >= 8'h20) && (char_data <= 8'h7E);

  // Row advance wraps to the top; row_base tracks row*COLS without a multiplier.
  assign row_wrap  = (row == LastRow);
  assign next_row  = row_wrap ? 5'd0 : row + 5'd1;
  assign next_base = row_wrap ? '0 : row_base + ColsA;

  assign cur_addr = row_base + ADDR_W'(col);
  assign clr_addr = row_base + clr_cnt;

  always_ff @(posedge CLK_CPU) begin
    if (reset) begin
      state    <= StIdle;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      clr_cnt  <= '0;
      we       <= 1'b0;
      addr     <= '0;
      data     <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        StIdle: begin
          if (accept) begin
            if (printable) begin
              we   <= 1'b1;
              addr <= cur_addr;
              data <= char_data;
              if (col == LastCol) begin
                col      <= '0;
                row      <= next_row;
                row_base <= next_base;
                clr_cnt  <= '0;
                state    <= StClearRow;
              end else begin
                col <= col + 6'd1;
              end
            end else begin
              case (char_data)
                ChLf: begin
                  col      <= '0;
                  row      <= next_row;
                  row_base <= next_base;
                  clr_cnt  <= '0;
                  state    <= StClearRow;
                end
                ChCr: col <= '0;
                ChBs: begin
                  if (col != 6'd0) begin
                    col  <= col - 6'd1;
                    we   <= 1'b1;
                    addr <= cur_addr - ADDR_W'(1);
                    data <= BLANK;
                  end
                end
                ChFf: begin
                  col      <= '0;
                  row      <= '0;
                  row_base <= '0;
                  clr_cnt  <= '0;
                  state    <= StClearAll;
                end
                default: ;
              endcase
            end
          end
        end
        StClearRow: begin
          we      <= 1'b1;
          addr    <= clr_addr;
          data    <= BLANK;
          clr_cnt <= clr_cnt + ADDR_W'(1);
          // Leave on the edge that loads the final blank so the next byte follows directly.
          if (clr_cnt == LastRowClr) state <= StIdle;
        end
        StClearAll: begin
          we      <= 1'b1;
          addr    <= clr_addr;
          data    <= BLANK;
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == LastAllClr) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign video_write_enable = we;
  assign video_write_addr   = addr;
  assign video_write_data   = data;
  assign cursor_col         = col;
  assign cursor_row         = row;

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console: handshake, cursor moves, control codes and clears.
module tb_text_console;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        we;
  logic [10:0] addr;
  logic [7:0]  wdata;
  logic [5:0]  ccol;
  logic [4:0]  crow;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  text_console #(
    .COLS  (50),
    .ROWS  (30),
    .ADDR_W(11),
    .BLANK (8'h20)
  ) dut (
    .CLK_CPU           (clk),
    .reset             (reset),
    .char_valid        (char_valid),
    .char_data         (char_data),
    .char_ready        (char_ready),
    .video_write_enable(we),
    .video_write_addr  (addr),
    .video_write_data  (wdata),
    .cursor_col        (ccol),
    .cursor_row        (crow)
  );

  // Advance one edge and land just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for one edge (caller guarantees char_ready).
  task automatic send(input logic [7:0] b);
    char_valid = 1'b1;
    char_data  = b;
    step();
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!char_ready && n < 2000) begin
      step();
      n++;
    end
    total++;
    if (char_ready !== 1'b1) $display("FAIL %s: char_ready stuck at %b, want 1", name, char_ready);
    else passed++;
  endtask

  // Checks K blank writes from base, then char_ready back exactly after K low cycles.
  task automatic check_clear(input string name, input int base, input int k, input int low0);
    int low = low0;
    int shown = 0;
    for (int i = 0; i < k; i++) begin
      step();
      total++;
      if ({we, addr, wdata} !== {1'b1, 11'(base + i), 8'h20}) begin
        if (shown < 5)
          $display("FAIL %s[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=20",
                   name, i, we, addr, wdata, base + i);
        shown++;
      end else passed++;
      if (!char_ready) low++;
    end
    total++;
    if (low !== k) $display("FAIL %s ready_low: got %0d cycles want %0d", name, low, k);
    else passed++;
    total++;
    if (char_ready !== 1'b1) $display("FAIL %s ready_end: got %b want 1", name, char_ready);
    else passed++;
    step();
    total++;
    if (we !== 1'b0) $display("FAIL %s tail_we: got %b want 0", name, we);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    char_valid = 1'b0;
    char_data = 8'h00;
    step();
    step();
    reset = 1'b0;
    total++;
    if ({we, addr, wdata} !== 20'h0) $display("FAIL reset_wr: got we=%b addr=%0d data=%h want 0/0/00", we, addr, wdata);
    else passed++;
    total++;
    if ({char_ready, ccol, crow} !== {1'b1, 6'd0, 5'd0})
      $display("FAIL reset_cur: got ready=%b col=%0d row=%0d want 1/0/0", char_ready, ccol, crow);
    else passed++;
  endtask

  task automatic test_back_to_back();
    char_valid = 1'b1;
    char_data  = 8'h41;
    step();
    total++;
    if ({we, addr, wdata, char_ready} !== {1'b1, 11'd0, 8'h41, 1'b1})
      $display("FAIL ab_A: got we=%b addr=%0d data=%h ready=%b want 1/0/41/1", we, addr, wdata, char_ready);
    else passed++;
    char_data = 8'h42;
    step();
    char_valid = 1'b0;
    total++;
    if ({we, addr, wdata, char_ready} !== {1'b1, 11'd1, 8'h42, 1'b1})
      $display("FAIL ab_B: got we=%b addr=%0d data=%h ready=%b want 1/1/42/1", we, addr, wdata, char_ready);
    else passed++;
    total++;
    if (ccol !== 6'd2) $display("FAIL ab_col: got %0d want 2", ccol);
    else passed++;
    step();
    total++;
    if (we !== 1'b0) $display("FAIL ab_idle_we: got %b want 0", we);
    else passed++;
  endtask

  task automatic test_last_column();
    for (int i = 0; i < 47; i++) send(8'h78);
    total++;
    if ({crow, ccol} !== {5'd0, 6'd49}) $display("FAIL lc_pre: got row=%0d col=%0d want 0/49", crow, ccol);
    else passed++;
    send(8'h43);
    total++;
    if ({we, addr, wdata} !== {1'b1, 11'd49, 8'h43})
      $display("FAIL lc_char: got we=%b addr=%0d data=%h want 1/49/43", we, addr, wdata);
    else passed++;
    total++;
    if ({crow, ccol, char_ready} !== {5'd1, 6'd0, 1'b0})
      $display("FAIL lc_cur: got row=%0d col=%0d ready=%b want 1/0/0", crow, ccol, char_ready);
    else passed++;
    check_clear("lc_clear", 50, 50, 1);
  endtask

  task automatic test_lf_wrap();
    for (int i = 0; i < 28; i++) begin
      send(8'h0A);
      wait_ready("lf_walk");
    end
    total++;
    if (crow !== 5'd29) $display("FAIL lf_pre: got row=%0d want 29", crow);
    else passed++;
    send(8'h0A);
    total++;
    if ({we, crow, ccol, char_ready} !== {1'b0, 5'd0, 6'd0, 1'b0})
      $display("FAIL lf_wrap: got we=%b row=%0d col=%0d ready=%b want 0/0/0/0", we, crow, ccol, char_ready);
    else passed++;
    check_clear("lf_clear", 0, 50, 1);
  endtask

  task automatic test_bs_cr();
    for (int i = 0; i < 3; i++) begin
      send(8'h0A);
      wait_ready("bs_walk");
    end
    for (int i = 0; i < 10; i++) send(8'h61);
    total++;
    if ({crow, ccol} !== {5'd3, 6'd10}) $display("FAIL bs_pre: got row=%0d col=%0d want 3/10", crow, ccol);
    else passed++;
    send(8'h08);
    total++;
    if ({we, addr, wdata, crow, ccol} !== {1'b1, 11'd159, 8'h20, 5'd3, 6'd9})
      $display("FAIL bs_write: got we=%b addr=%0d data=%h row=%0d col=%0d want 1/159/20/3/9",
               we, addr, wdata, crow, ccol);
    else passed++;
    send(8'h0D);
    total++;
    if ({we, crow, ccol} !== {1'b0, 5'd3, 6'd0})
      $display("FAIL cr: got we=%b row=%0d col=%0d want 0/3/0", we, crow, ccol);
    else passed++;
    send(8'h08);
    total++;
    if ({we, crow, ccol} !== {1'b0, 5'd3, 6'd0})
      $display("FAIL bs_col0: got we=%b row=%0d col=%0d want 0/3/0", we, crow, ccol);
    else passed++;
  endtask

  task automatic test_ignored();
    char_valid = 1'b1;
    char_data  = 8'h01;
    step();
    total++;
    if ({we, crow, ccol, char_ready} !== {1'b0, 5'd3, 6'd0, 1'b1})
      $display("FAIL ign_01: got we=%b row=%0d col=%0d ready=%b want 0/3/0/1", we, crow, ccol, char_ready);
    else passed++;
    char_data = 8'h7F;
    step();
    char_valid = 1'b0;
    total++;
    if ({we, crow, ccol, char_ready} !== {1'b0, 5'd3, 6'd0, 1'b1})
      $display("FAIL ign_7f: got we=%b row=%0d col=%0d ready=%b want 0/3/0/1", we, crow, ccol, char_ready);
    else passed++;
  endtask

  task automatic test_clear_all();
    send(8'h0C);
    total++;
    if ({we, crow, ccol, char_ready} !== {1'b0, 5'd0, 6'd0, 1'b0})
      $display("FAIL ff_entry: got we=%b row=%0d col=%0d ready=%b want 0/0/0/0", we, crow, ccol, char_ready);
    else passed++;
    check_clear("ff_clear", 0, 1500, 1);
  endtask

  task automatic test_reset_abort();
    send(8'h0C);
    for (int i = 0; i < 700; i++) step();
    total++;
    if ({we, addr} !== {1'b1, 11'd699}) $display("FAIL abort_pre: got we=%b addr=%0d want 1/699", we, addr);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({we, char_ready, crow, ccol} !== {1'b0, 1'b1, 5'd0, 6'd0})
      $display("FAIL abort: got we=%b ready=%b row=%0d col=%0d want 0/1/0/0", we, char_ready, crow, ccol);
    else passed++;
    send(8'h5A);
    total++;
    if ({we, addr, wdata} !== {1'b1, 11'd0, 8'h5A})
      $display("FAIL abort_next: got we=%b addr=%0d data=%h want 1/0/5a", we, addr, wdata);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_last_column();
    test_lf_wrap();
    test_bs_cr();
    test_ignored();
    test_clear_all();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
